regfile_param: RTL and testbench
================================

// Module: regfile_param
// PURPOSE
//  Parametrised register file built on the DFF storage primitive: DEPTH words of WIDTH bits.
//  Provides one synchronous write port and two asynchronous read ports (A, B).
//  Supersedes the fixed 4x16 register bank and feeds the CPU datapath operand buses.
//  Adds synchronous reset, optional write-to-read bypass and an optional hardwired zero register.
// PARAMETERS
//  WIDTH     16                    data bits per word
//  DEPTH     4                     number of words, >=2; need not be a power of two
//  ADDR_W    $clog2(DEPTH)         address bits (derived; do not override)
//  BYPASS    1                     1: a same-cycle write to the read address forwards wdata to rdata
//  ZERO_REG  0                     1: word 0 reads 0 and ignores writes
// PORTS
//  clk      in   1       clock; all state updates on the rising edge
//  reset    in   1       synchronous, active-high; clears every word
//  we       in   1       write enable
//  waddr    in   ADDR_W  write address
//  wdata    in   WIDTH   write data
//  raddr_a  in   ADDR_W  read address, port A
//  raddr_b  in   ADDR_W  read address, port B
//  rdata_a  out  WIDTH   read data, port A (combinational)
//  rdata_b  out  WIDTH   read data, port B (combinational)
// BEHAVIOUR
//  - Reset: at a rising clk edge with reset=1, all words become 0. Reset overrides we, and the write is dropped.
//  - While reset=1, rdata_a and rdata_b are forced to 0 and bypass is suppressed.
//  - Write: at a rising clk edge with reset=0 and we=1, mem[waddr] <= wdata. Latency 1 edge. No other word changes.
//  - Read: rdata_x = mem[raddr_x], combinational, 0 clock latency. Both ports are independent; equal addresses are legal.
//  - Bypass (BYPASS=1): if reset=0, we=1 and waddr==raddr_x, then rdata_x = wdata in the same cycle.
//  - BYPASS=0: rdata_x shows the old value until after the edge.
//  - ZERO_REG=1: writes to address 0 are ignored, reads of address 0 return 0, and address 0 is never bypassed.
//  - Out-of-range address (>= DEPTH): writes are ignored, reads return 0, and the address is never bypassed.
//  - Simultaneous write and read of the same word without bypass: the read returns the pre-edge value.
//  - Reset mid-sequence: contents clear at that edge; the first write after reset deasserts is honoured normally.
//  - Held value: with we=0 every word holds indefinitely, independent of wdata and waddr activity.
// STRUCTURE
//  - Shared package regfile_pkg holds the default constants RF_WIDTH=16 and RF_DEPTH=4.
//  - The package also holds the typedef rf_word_t = logic [RF_WIDTH-1:0].
//  - Sub-module reg_n #(WIDTH): one word.
//    - Ports: clk, reset, load, d, q.
//    - q <= 0 on reset, else d when load, else hold.
//    - Built from DFF plus a 2:1 mux per bit.
//  - Top level instantiates DEPTH x reg_n in a generate loop and adds:
//    - the write decoder (one-hot load from we/waddr, gated by range and ZERO_REG);
//    - two read muxes with bypass compare and reset/zero/range forcing.
// TESTING  (WIDTH=16, DEPTH=4 unless noted)
//  1. Reset, then read all 4 addresses on both ports -> every read returns 16'h0000.
//  2. Basic write/read:
//     - write 16'hBEEF@1, then 16'h1234@2 -> rdata_a(raddr=1)=16'hBEEF and rdata_b(raddr=2)=16'h1234 in the same cycle;
//     - 16'hBEEF@1 holds after 5 idle cycles with wdata toggling.
//  3. BYPASS=1: we=1, waddr=3, wdata=16'hA5A5, raddr_a=3 -> rdata_a=16'hA5A5 before the edge.
//     BYPASS=0, same stimulus -> old value before the edge, 16'hA5A5 after.
//  4. Reset with we=1, waddr=1, wdata=16'hFFFF at the same edge -> mem[1]=0 afterwards, and rdata=0 while reset=1.
//  5. ZERO_REG=1: write 16'h7777@0 -> reading address 0 gives 0 on both ports, including the bypass cycle.
//     Writes to addresses 1..3 are unaffected.
//  6. DEPTH=3 (ADDR_W=2): write 16'h5555@3 -> ignored; reading address 3 gives 0; words 0..2 are unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and word type for the parametrised register file.
package regfile_pkg;

    localparam int unsigned RF_WIDTH = 16;
    localparam int unsigned RF_DEPTH = 4;

    typedef logic [RF_WIDTH-1:0] rf_word_t;

endpackage

// File: rtl/reg_n.sv
// One register-file word: a WIDTH-bit DFF bank with a load mux and synchronous clear.
module reg_n #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] d_mux;

    assign d_mux = load ? d : q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= d_mux;
        end
    end

endmodule

// File: rtl/regfile_param.sv
// DEPTH x WIDTH register file: one synchronous write port, two combinational read ports,
// optional write-to-read bypass and optional hardwired zero word.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = RF_WIDTH,
    parameter int unsigned DEPTH    = RF_DEPTH,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b
);

    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    logic [WIDTH-1:0] q [DEPTH];
    logic [DEPTH-1:0] load;

    // An address is live if it maps to a real word that is not the hardwired zero.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_L) && !(ZERO_REG && (a == '0));
    endfunction

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        assign load[i] = we && (waddr == ADDR_W'(i)) && addr_ok(waddr);

        reg_n #(
            .WIDTH(WIDTH)
        ) u_word (
            .clk  (clk),
            .reset(reset),
            .load (load[i]),
            .d    (wdata),
            .q    (q[i])
        );
    end

    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (raddr_a == ADDR_W'(i)) rdata_a = q[i];
            if (raddr_b == ADDR_W'(i)) rdata_b = q[i];
        end
        if (BYPASS && we && (waddr == raddr_a)) rdata_a = wdata;
        if (BYPASS && we && (waddr == raddr_b)) rdata_b = wdata;
        // Forcing comes last so it also masks any bypass.
        if (reset || !addr_ok(raddr_a)) rdata_a = '0;
        if (reset || !addr_ok(raddr_b)) rdata_b = '0;
    end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench: four register-file variants share one stimulus stream.
module tb_regfile_param;
    import regfile_pkg::*;

    typedef struct packed {
        logic [1:0] dut;
        logic       port;
        rf_word_t   val;
    } item_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       we;
    logic [1:0] waddr;
    rf_word_t   wdata;
    logic [1:0] raddr_a;
    logic [1:0] raddr_b;
    rf_word_t   ra [4];
    rf_word_t   rb [4];

    item_t exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    event  sample_ev;

    always #5 clk = ~clk;

    // u0: defaults, u1: no bypass, u2: zero register, u3: three words
    regfile_param u0 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra[0]), .rdata_b(rb[0])
    );
    regfile_param #(.BYPASS(1'b0)) u1 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra[1]), .rdata_b(rb[1])
    );
    regfile_param #(.ZERO_REG(1'b1)) u2 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra[2]), .rdata_b(rb[2])
    );
    regfile_param #(.DEPTH(3)) u3 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra[3]), .rdata_b(rb[3])
    );

    // Monitor: on each sample strobe, drain the expectations and compare.
    initial begin
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                item_t    it;
                string    nm;
                rf_word_t act;
                it  = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = it.port ? rb[it.dut] : ra[it.dut];
                checks++;
                if (act !== it.val) begin
                    errors++;
                    $display("FAIL %s dut%0d port %s: got %h expected %h",
                             nm, it.dut, it.port ? "b" : "a", act, it.val);
                end
            end
        end
    end

    task automatic drive(input logic r, input logic w, input logic [1:0] wa, input rf_word_t wd,
                         input logic [1:0] a, input logic [1:0] b);
        reset   = r;
        we      = w;
        waddr   = wa;
        wdata   = wd;
        raddr_a = a;
        raddr_b = b;
    endtask

    task automatic expect4(input string n,
                           input rf_word_t a0, input rf_word_t a1, input rf_word_t a2,
                           input rf_word_t a3, input rf_word_t b0, input rf_word_t b1,
                           input rf_word_t b2, input rf_word_t b3);
        rf_word_t av [4];
        rf_word_t bv [4];
        item_t    it;
        av = '{a0, a1, a2, a3};
        bv = '{b0, b1, b2, b3};
        for (int d = 0; d < 4; d++) begin
            it.dut  = 2'(d);
            it.port = 1'b0;
            it.val  = av[d];
            exp_q.push_back(it);
            name_q.push_back(n);
            it.port = 1'b1;
            it.val  = bv[d];
            exp_q.push_back(it);
            name_q.push_back(n);
        end
    endtask

    // Sample mid-cycle, then move on to the next negative edge (one rising edge later).
    task automatic tick();
        #1;
        -> sample_ev;
        @(negedge clk);
    endtask

    initial begin
        drive(1'b1, 1'b0, 2'd0, 16'h0, 2'd0, 2'd0);
        @(negedge clk);
        expect4("in_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Cleared contents on every address
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 2'd0, 16'h0, 2'(i), 2'(i));
            expect4("reset_clear", 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end

        // Basic writes; pre-edge bypass visible except with BYPASS=0
        drive(1'b0, 1'b1, 2'd1, 16'hBEEF, 2'd1, 2'd0);
        expect4("wr1_pre", 16'hBEEF, 0, 16'hBEEF, 16'hBEEF, 0, 0, 0, 0);
        tick();
        drive(1'b0, 1'b1, 2'd2, 16'h1234, 2'd1, 2'd2);
        expect4("wr2_pre", 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF,
                16'h1234, 0, 16'h1234, 16'h1234);
        tick();
        drive(1'b0, 1'b0, 2'd0, 16'h0, 2'd1, 2'd2);
        expect4("rd_both", 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF,
                16'h1234, 16'h1234, 16'h1234, 16'h1234);
        tick();

        // Idle cycles with wdata/waddr churn must not disturb contents
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 2'(k), (k % 2 == 1) ? 16'hFFFF : 16'h0000, 2'd1, 2'd2);
            expect4("hold", 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF,
                    16'h1234, 16'h1234, 16'h1234, 16'h1234);
            tick();
        end

        // Bypass vs. no bypass on word 3; word 3 does not exist in u3
        drive(1'b0, 1'b1, 2'd3, 16'hA5A5, 2'd3, 2'd3);
        expect4("byp_pre", 16'hA5A5, 0, 16'hA5A5, 0, 16'hA5A5, 0, 16'hA5A5, 0);
        tick();
        drive(1'b0, 1'b0, 2'd0, 16'h0, 2'd3, 2'd3);
        expect4("byp_post", 16'hA5A5, 16'hA5A5, 16'hA5A5, 0, 16'hA5A5, 16'hA5A5, 16'hA5A5, 0);
        tick();

        // Writes to word 0: ignored and never bypassed in the zero-register variant
        drive(1'b0, 1'b1, 2'd0, 16'h7777, 2'd0, 2'd0);
        expect4("zero_pre", 16'h7777, 0, 0, 16'h7777, 16'h7777, 0, 0, 16'h7777);
        tick();
        drive(1'b0, 1'b0, 2'd0, 16'h0, 2'd0, 2'd0);
        expect4("zero_post", 16'h7777, 16'h7777, 0, 16'h7777, 16'h7777, 16'h7777, 0, 16'h7777);
        tick();
        drive(1'b0, 1'b0, 2'd0, 16'h0, 2'd1, 2'd2);
        expect4("others", 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF,
                16'h1234, 16'h1234, 16'h1234, 16'h1234);
        tick();
        drive(1'b0, 1'b0, 2'd0, 16'h0, 2'd3, 2'd0);
        expect4("mixed", 16'hA5A5, 16'hA5A5, 16'hA5A5, 0, 16'h7777, 16'h7777, 0, 16'h7777);
        tick();

        // Out-of-range write in the three-word variant
        drive(1'b0, 1'b1, 2'd3, 16'h5555, 2'd3, 2'd1);
        expect4("oor_pre", 16'h5555, 16'hA5A5, 16'h5555, 0,
                16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF);
        tick();
        drive(1'b0, 1'b0, 2'd0, 16'h0, 2'd3, 2'd2);
        expect4("oor_post", 16'h5555, 16'h5555, 16'h5555, 0,
                16'h1234, 16'h1234, 16'h1234, 16'h1234);
        tick();
        drive(1'b0, 1'b0, 2'd0, 16'h0, 2'd0, 2'd1);
        expect4("oor_words", 16'h7777, 16'h7777, 0, 16'h7777,
                16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF);
        tick();

        // Reset overrides a simultaneous write and masks reads and bypass
        drive(1'b1, 1'b1, 2'd1, 16'hFFFF, 2'd1, 2'd2);
        expect4("rst_wr", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1'b0, 1'b0, 2'd0, 16'h0, 2'd1, 2'd2);
        expect4("after_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1'b0, 1'b1, 2'd2, 16'h0F0F, 2'd0, 2'd3);
        tick();
        drive(1'b0, 1'b0, 2'd0, 16'h0, 2'd1, 2'd2);
        expect4("wr_after_rst", 0, 0, 0, 0, 16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F);
        tick();

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
